// File: rtl/mux3_pkg.sv
// Shared select-code definitions for the 3:1 datapath mux.
package mux3_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_IN1 = 2'd0;
    localparam sel_t SEL_IN2 = 2'd1;
    localparam sel_t SEL_IN3 = 2'd2;
    localparam sel_t SEL_BAD = 2'd3;

endpackage : mux3_pkg

// File: rtl/mux_3_to_1_core.sv
// Combinational 3:1 decode; the unused select code (and any unknown select) drives ILLEGAL_VAL.
module mux_3_to_1_core
    import mux3_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int ILLEGAL_VAL = 0
) (
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [WIDTH-1:0] i_in3,
    input  sel_t             i_sel,
    output logic [WIDTH-1:0] o_out1
);

    localparam logic [WIDTH-1:0] ILL_W = WIDTH'(ILLEGAL_VAL);

    // Select decode; the default arm also absorbs X/Z selects.
    always_comb begin
        o_out1 = ILL_W;
        case (i_sel)
            SEL_IN1: o_out1 = i_in1;
            SEL_IN2: o_out1 = i_in2;
            SEL_IN3: o_out1 = i_in3;
            default: o_out1 = ILL_W;
        endcase
    end

endmodule : mux_3_to_1_core

// File: rtl/mux_3_to_1.sv
// 3:1 mux with a same-cycle output and a registered copy for the next stage.
// Define MUX3_SEL_CHECK_EN to add the sticky sel_err illegal-select flag.
module mux_3_to_1
    import mux3_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int ILLEGAL_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  sel_t             sel,
    output logic [WIDTH-1:0] out1,
`ifdef MUX3_SEL_CHECK_EN
    output logic             sel_err,
`endif
    output logic [WIDTH-1:0] out1_q
);

    logic [WIDTH-1:0] w_out1;
    logic [WIDTH-1:0] r_out1_q;

    mux_3_to_1_core #(
        .WIDTH       (WIDTH),
        .ILLEGAL_VAL (ILLEGAL_VAL)
    ) u_core (
        .i_in1  (in1),
        .i_in2  (in2),
        .i_in3  (in3),
        .i_sel  (sel),
        .o_out1 (w_out1)
    );

    // Pipeline copy of the mux result, cleared while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out1_q <= '0;
        end else begin
            r_out1_q <= w_out1;
        end
    end

    assign out1   = w_out1;
    assign out1_q = r_out1_q;

`ifdef MUX3_SEL_CHECK_EN
    logic r_sel_err;

    // Sticky flag: once an illegal select is sampled it holds until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (sel == SEL_BAD) begin
            r_sel_err <= 1'b1;
        end else begin
            r_sel_err <= r_sel_err;
        end
    end

    assign sel_err = r_sel_err;
`endif

endmodule : mux_3_to_1

// File: tb/tb_mux_3_to_1.sv
// Self-checking bench for mux_3_to_1 with a table-lookup reference model.
module tb_mux_3_to_1;

    localparam int WIDTH       = 5;
    localparam int ILLEGAL_VAL = 0;
    localparam logic [WIDTH-1:0] ILL_W = WIDTH'(ILLEGAL_VAL);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out1_q;
`ifdef MUX3_SEL_CHECK_EN
    logic             sel_err;
`endif

    int checks = 0;
    int errors = 0;

    mux_3_to_1 #(
        .WIDTH       (WIDTH),
        .ILLEGAL_VAL (ILLEGAL_VAL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .sel     (sel),
        .out1    (out1),
`ifdef MUX3_SEL_CHECK_EN
        .sel_err (sel_err),
`endif
        .out1_q  (out1_q)
    );

    always #5 clk = ~clk;

    // Reference: pick the sel-th entry of the input list, else the illegal value.
    function automatic logic [WIDTH-1:0] ref_mux(input logic [1:0] s,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] tbl [3];
        tbl[0] = a;
        tbl[1] = b;
        tbl[2] = c;
        if (int'(s) < 3) return tbl[int'(s)];
        return ILL_W;
    endfunction

    task automatic test_reset_x();
        #1;
        checks++;
        if ($isunknown(out1) || out1 !== ILL_W) begin
            errors++;
            $display("FAIL reset_x_out1: got %h want %h", out1, ILL_W);
        end
        checks++;
        if (out1_q !== '0) begin
            errors++;
            $display("FAIL reset_out1_q: got %h want 00", out1_q);
        end
`ifdef MUX3_SEL_CHECK_EN
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_sel_err: got %b want 0", sel_err);
        end
`endif
    endtask

    task automatic test_decode();
        @(negedge clk);
        rst_n = 1'b1;
        in1 = 5'd0; in2 = 5'd1; in3 = 5'd2;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            sel = 2'(s);
            #1;
            checks++;
            if (out1 !== 5'(s)) begin
                errors++;
                $display("FAIL decode_sel%0d: got %h want %h", s, out1, 5'(s));
            end
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        sel = 2'd3;
        #1;
        checks++;
        if (out1 !== ILL_W) begin
            errors++;
            $display("FAIL illegal_out1: got %h want %h", out1, ILL_W);
        end
`ifdef MUX3_SEL_CHECK_EN
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL sel_err_before_edge: got %b want 0", sel_err);
        end
        @(posedge clk); #1;
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_set: got %b want 1", sel_err);
        end
        @(negedge clk);
        sel = 2'd0;
        @(posedge clk); #1;
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_sticky: got %b want 1", sel_err);
        end
`endif
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out1_q !== '0) begin
            errors++;
            $display("FAIL reg_in_reset: got %h want 00", out1_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sel = 2'd2;
        in3 = 5'h1F;
        #1;
        checks++;
        if (out1_q !== '0) begin
            errors++;
            $display("FAIL reg_before_first_edge: got %h want 00", out1_q);
        end
        @(posedge clk); #1;
        checks++;
        if (out1_q !== 5'h1F) begin
            errors++;
            $display("FAIL reg_first_capture: got %h want 1f", out1_q);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
`ifdef MUX3_SEL_CHECK_EN
        sel = 2'd3;
        @(posedge clk);
        #2;
        sel = 2'd2;
`endif
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out1_q !== '0) begin
            errors++;
            $display("FAIL async_out1_q: got %h want 00", out1_q);
        end
        checks++;
        if (out1 !== 5'h1F) begin
            errors++;
            $display("FAIL async_out1: got %h want 1f", out1);
        end
`ifdef MUX3_SEL_CHECK_EN
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL async_sel_err: got %b want 0", sel_err);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_input_change();
        logic [WIDTH-1:0] held_q;
        @(negedge clk);
        sel = 2'd1;
        in2 = 5'h0A;
        @(posedge clk); #1;
        held_q = 5'h0A;
        checks++;
        if (out1_q !== held_q) begin
            errors++;
            $display("FAIL chg_q_initial: got %h want %h", out1_q, held_q);
        end
        in2 = 5'h15;
        #0;
        #1;
        checks++;
        if (out1 !== 5'h15) begin
            errors++;
            $display("FAIL chg_out1: got %h want 15", out1);
        end
        checks++;
        if (out1_q !== held_q) begin
            errors++;
            $display("FAIL chg_q_held: got %h want %h", out1_q, held_q);
        end
        @(posedge clk); #1;
        checks++;
        if (out1_q !== 5'h15) begin
            errors++;
            $display("FAIL chg_q_next_edge: got %h want 15", out1_q);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] exp_c;
        logic [WIDTH-1:0] exp_q;
        logic             exp_err;
        exp_err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in1 = 5'($urandom);
            in2 = 5'($urandom);
            in3 = 5'($urandom);
            sel = 2'($urandom_range(0, 3));
            exp_c = ref_mux(sel, in1, in2, in3);
            #1;
            checks++;
            if (out1 !== exp_c) begin
                errors++;
                $display("FAIL rand_out1[%0d]: sel=%0d got %h want %h", i, sel, out1, exp_c);
            end
            exp_q = exp_c;
            if (sel == 2'd3) exp_err = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out1_q !== exp_q) begin
                errors++;
                $display("FAIL rand_out1_q[%0d]: got %h want %h", i, out1_q, exp_q);
            end
`ifdef MUX3_SEL_CHECK_EN
            checks++;
            if (sel_err !== exp_err) begin
                errors++;
                $display("FAIL rand_sel_err[%0d]: got %b want %b", i, sel_err, exp_err);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset_x();
        test_decode();
        test_illegal();
        test_registered();
        test_async_reset();
        test_input_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mux_3_to_1
